seq_divider: RTL

- Parametrised multi-cycle integer divider; next generation of the team's 8-bit repeated-subtraction divider.
- Uses restoring shift-subtract, one quotient bit per cycle, so latency is fixed and data-independent.
- Adds divide-by-zero flagging and valid/ready handshakes on both sides.
- Sits as a shared arithmetic unit behind a requester; one operation in flight.

---
 rtl/seq_divider.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock, one op in flight.
// Latency: out_valid rises WIDTH edges after accept (divisor != 0), or on the accept edge itself (divisor == 0).
// Backpressure: result held in DONE until out_ready; in_ready is registered and rises on the DONE -> IDLE edge.
//
// Ports: clk/rst (sync active-high), in_valid/in_ready + dividend/divisor (request side),
//        out_valid/out_ready + quotient/remainder/div_by_zero (result side).
// Optional feature: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r_q;      // partial remainder
    logic [WIDTH-1:0] q_q;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_q;      // divisor (magnitude in signed builds)
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   t;
    logic             ge;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;

    // The trial value keeps the full partial remainder plus one extra bit:
    // with a divisor above 2^(WIDTH-1) the remainder MSB can be set, and
    // dropping it would corrupt the compare.
    always_comb begin
        t     = {r_q, q_q[WIDTH-1]};
        ge    = (t >= {1'b0, d_q});
        r_nxt = ge ? (t[WIDTH-1:0] - d_q) : t[WIDTH-1:0];
        q_nxt = {q_q[WIDTH-2:0], ge};
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_a;
    logic neg_b;

    // Iterate on magnitudes; the most-negative value maps onto itself, which
    // is still the correct unsigned magnitude, so -MIN / -1 wraps naturally.
    always_comb begin
        a_op  = dividend[WIDTH-1] ? -dividend : dividend;
        b_op  = divisor[WIDTH-1]  ? -divisor  : divisor;
        q_fin = (neg_a ^ neg_b) ? -q_nxt : q_nxt;
        r_fin = neg_a ? -r_nxt : r_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_a <= 1'b0;
            neg_b <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            neg_a <= dividend[WIDTH-1];
            neg_b <= divisor[WIDTH-1];
        end
    end
`else
    assign a_op  = dividend;
    assign b_op  = divisor;
    assign q_fin = q_nxt;
    assign r_fin = r_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_q      <= '0;
                        q_q      <= a_op;
                        d_q      <= b_op;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            // No iterations needed: publish the flagged result now.
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= q_fin;
                        remainder   <= r_fin;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
